serv_pc_seq: RTL



---
 rtl/serv_pc_seq_pkg.sv | 24 ++
 rtl/serv_bitcnt.sv | 47 ++++
 rtl/serv_pc_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serv_pc_seq_pkg.sv
// Shared types and constants for the bit-serial PC sequencer.
//   state_e          : sequencer state (FETCH, DECODE, RUN, TRAP)
//   CNT_W            : bit-counter width
//   CNT_LAST         : last bit position of a 32-cycle pass
//   CNT_IMM_HI_START : first bit position of the 12..31 phase strobe
package serv_pc_seq_pkg;

  localparam int unsigned CNT_W            = 5;
  localparam int unsigned CNT_LAST         = 31;
  localparam int unsigned CNT_IMM_HI_START = 12;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    RUN    = 2'd2,
    TRAP   = 2'd3
  } state_e;

  // A state that shifts the PC (and clocks the bit counter).
  function automatic logic is_serial_pass(input state_e s);
    return (s == RUN) || (s == TRAP);
  endfunction

endpackage

// File: rtl/serv_bitcnt.sv
// 5-bit serial bit counter with phase-strobe decode.
// Ports:
//   clk, i_rst   : clock, asynchronous active-high reset
//   i_en         : count enable; strobes are forced low while disabled
//   o_cnt0/1/2   : phase strobes for bit 0, 1, 2
//   o_cnt12to31  : phase strobe for bits 12..31
//   o_cnt_done   : phase strobe for the last bit (31)
module serv_bitcnt
  import serv_pc_seq_pkg::*;
(
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt12to31,
  output logic o_cnt_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment while enabled; the 31 -> 0 wrap is the natural overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by i_en so idle states never show a phase strobe at cnt==0.
  assign o_cnt0      = i_en && (cnt_q == CNT_W'(0));
  assign o_cnt1      = i_en && (cnt_q == CNT_W'(1));
  assign o_cnt2      = i_en && (cnt_q == CNT_W'(2));
  assign o_cnt12to31 = i_en && (cnt_q >= CNT_W'(CNT_IMM_HI_START));
  assign o_cnt_done  = i_en && (cnt_q == CNT_W'(CNT_LAST));

endmodule

// File: rtl/serv_pc_seq.sv
// Sequencer for the bit-serial PC datapath: fetch/decode/run/trap FSM,
// bit-counter phase strobes, instruction-bus request and misaligned-target
// trap scheduling.
// Parameters:
//   WITH_CSR        : 1 enables trap sequencing (misalign and IRQ)
//   WITH_COMPRESSED : 1 allows halfword-aligned targets (no bit1 check)
// Ports:
//   clk, i_rst      : clock, asynchronous active-high reset
//   i_ibus_ack      : instruction fetch complete (pulse, honoured in FETCH)
//   i_dec_valid     : decoded instruction available (sampled in DECODE)
//   i_jump          : current instruction redirects the PC
//   i_bad_pc        : serial jump-target bit from the PC datapath
//   i_irq           : masked level interrupt request
//   o_ibus_cyc      : instruction fetch request
//   o_pc_en         : PC shift enable
//   o_cnt0/1/2      : bit-counter phase strobes
//   o_cnt12to31     : bit-counter phase 12..31
//   o_cnt_done      : bit-counter phase 31
//   o_trap          : current pass loads the trap vector
//   o_misalign      : sticky cause flag for the last trap
module serv_pc_seq
  import serv_pc_seq_pkg::*;
#(
  parameter bit WITH_CSR        = 1'b1,
  parameter bit WITH_COMPRESSED = 1'b0
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_ibus_ack,
  input  logic i_dec_valid,
  input  logic i_jump,
  input  logic i_bad_pc,
  input  logic i_irq,
  output logic o_ibus_cyc,
  output logic o_pc_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt12to31,
  output logic o_cnt_done,
  output logic o_trap,
  output logic o_misalign
);

  // Bit1 of the target is only checked when traps exist and halfword
  // targets are illegal; bit0 is forced aligned by the datapath.
  localparam bit CHECK_MISALIGN = WITH_CSR && !WITH_COMPRESSED;

  state_e state_q;
  state_e state_d;
  logic   misalign_pend_q;
  logic   misalign_pend_d;
  logic   misalign_q;
  logic   misalign_d;
  logic   pass_en;

  assign pass_en = is_serial_pass(state_q);

  serv_bitcnt u_bitcnt (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_en        (pass_en),
    .o_cnt0      (o_cnt0),
    .o_cnt1      (o_cnt1),
    .o_cnt2      (o_cnt2),
    .o_cnt12to31 (o_cnt12to31),
    .o_cnt_done  (o_cnt_done)
  );

  // Next-state and sticky-flag logic.
  always_comb begin
    state_d         = state_q;
    misalign_pend_d = misalign_pend_q;
    misalign_d      = misalign_q;

    unique case (state_q)
      FETCH: begin
        if (i_ibus_ack) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        // IRQ beats a valid decode; the instruction is dropped unexecuted.
        if (WITH_CSR && i_irq) begin
          state_d    = TRAP;
          misalign_d = 1'b0;
        end else if (i_dec_valid) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (CHECK_MISALIGN && i_jump && o_cnt1) begin
          misalign_pend_d = i_bad_pc;
        end
        if (o_cnt_done) begin
          if (misalign_pend_q) begin
            state_d         = TRAP;
            misalign_d      = 1'b1;
            misalign_pend_d = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end
      end

      TRAP: begin
        if (o_cnt_done) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= FETCH;
      misalign_pend_q <= 1'b0;
      misalign_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      misalign_pend_q <= misalign_pend_d;
      misalign_q      <= misalign_d;
    end
  end

  // Request is held off while reset is asserted so it first appears on release.
  assign o_ibus_cyc = (state_q == FETCH) && !i_rst;
  assign o_pc_en    = pass_en;
  assign o_trap     = WITH_CSR && (state_q == TRAP);
  assign o_misalign = misalign_q;

endmodule
